// File: rtl/rom_arbiter.sv
// Two-port (IF, D) arbiter for a single async-read program ROM: fixed D priority,
// IF anti-starvation override, one-cycle registered response. Optional: ROM_ARB_ALIGN_CHK_EN.

// Per-requester response data register; zero forces an all-zero word on capture.
module rom_arb_rsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap,
  input  logic        zero,
  input  logic [31:0] rom_rd,
  output logic [31:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (cap) rdata <= zero ? 32'h0 : rom_rd;
  end
endmodule

module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [31:0]              if_rdata,
  output logic                     if_err,
  input  logic                     d_req,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [31:0]              rom_rd
);
  localparam int AW   = ADDRESS_WIDTH;
  localparam int NP   = 2;
  localparam int P_IF = 0;
  localparam int P_D  = 1;
  localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
  } arb_req_t;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_e;

  arb_req_t [NP-1:0]        rq;
  logic [NP-1:0]            gnt;
  logic [NP-1:0]            zero;
  logic [NP-1:0][31:0]      rdata;
  logic [SW-1:0]            starve_cnt;
  logic                     force_if;
  logic                     if_mis;
  logic                     issue;
  logic [AW-1:0]            last_addr;
  owner_e                   owner;

  assign rq[P_IF] = {if_req, if_addr};
  assign rq[P_D]  = {d_req, d_addr};

`ifdef ROM_ARB_ALIGN_CHK_EN
  assign if_mis = (if_addr[1:0] != 2'b00);
`else
  assign if_mis = 1'b0;
`endif

  // LIMIT==0 makes this constantly true, so IF wins every tie.
  assign force_if  = (starve_cnt >= LIMIT);
  assign gnt[P_IF] = rq[P_IF].req & (~rq[P_D].req | force_if);
  assign gnt[P_D]  = rq[P_D].req & ~gnt[P_IF];
  assign if_gnt    = gnt[P_IF];
  assign d_gnt     = gnt[P_D];

  // A rejected misaligned IF never reaches the ROM, so the bus keeps its last address.
  assign issue    = gnt[P_D] | (gnt[P_IF] & ~if_mis);
  assign rom_addr = gnt[P_D]               ? rq[P_D].addr  :
                    (gnt[P_IF] & ~if_mis)  ? rq[P_IF].addr : last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      if (issue) last_addr <= rom_addr;
      if (gnt[P_IF])
        starve_cnt <= '0;
      else if (if_req && gnt[P_D] && starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
      if (gnt[P_IF])     owner <= OWN_IF;
      else if (gnt[P_D]) owner <= OWN_D;
      else               owner <= OWN_NONE;
    end
  end

  assign zero[P_IF] = if_mis;
  assign zero[P_D]  = 1'b0;

  for (genvar g = 0; g < NP; g++) begin : g_rsp
    rom_arb_rsp u_rsp (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap    (gnt[g]),
      .zero   (zero[g]),
      .rom_rd (rom_rd),
      .rdata  (rdata[g])
    );
  end

  assign if_rdata  = rdata[P_IF];
  assign d_rdata   = rdata[P_D];
  assign if_rvalid = (owner == OWN_IF);
  assign d_rvalid  = (owner == OWN_D);

`ifdef ROM_ARB_ALIGN_CHK_EN
  logic if_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) if_err_q <= 1'b0;
    else        if_err_q <= gnt[P_IF] & if_mis;
  end
  assign if_err = if_err_q;
`else
  assign if_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a byte-array ROM model; expected words are hand-derived.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0;
  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata, rom_addr, rom_rd;
  logic [7:0]  mem [0:255];
  int          n_chk = 0, n_err = 0;

  rom_arbiter #(.ADDRESS_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_addr(rom_addr), .rom_rd(rom_rd)
  );

  always #5 clk = ~clk;

  logic [7:0] ra;
  assign ra     = rom_addr[7:0];
  assign rom_rd = {mem[ra], mem[8'(ra + 8'd1)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd3)]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes at k>=8 equal k, so the word at a is {a, a+1, a+2, a+3}.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {a, 8'(a + 8'd1), 8'(a + 8'd2), 8'(a + 8'd3)};
  endfunction

  logic prev_if, prev_d, exp_if;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    mem[4] = 8'h13; mem[5] = 8'h00; mem[6] = 8'h50; mem[7] = 8'h00;

    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    chk("rst_if_err",    32'(if_err),    32'd0);
    chk("rst_if_rdata",  if_rdata,       32'h0);
    chk("rst_rom_addr",  rom_addr,       32'h0);
    rst_n = 1'b1;

    // IF only
    tick(); if_req = 1'b1; if_addr = 32'h4; #2;
    chk("if_gnt",      32'(if_gnt),    32'd1);
    chk("if_d_gnt",    32'(d_gnt),     32'd0);
    chk("if_rom_addr", rom_addr,       32'h4);
    tick(); if_req = 1'b0; #2;
    chk("if_rvalid",   32'(if_rvalid), 32'd1);
    chk("if_rdata",    if_rdata,       32'h1300_5000);
    chk("if_gnt_idle", 32'(if_gnt),    32'd0);
    tick(); #2;
    chk("if_rvalid_drop", 32'(if_rvalid), 32'd0);
    chk("if_rdata_hold",  if_rdata,       32'h1300_5000);
    chk("rom_addr_hold",  rom_addr,       32'h4);

    // contention: D x4 then IF, repeating
    prev_if = 1'b0; prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); if_req = 1'b1; d_req = 1'b1; if_addr = 32'h20; d_addr = 32'h30; #2;
      exp_if = ((i % 5) == 4);
      chk($sformatf("ct_if_gnt%0d", i), 32'(if_gnt), 32'(exp_if));
      chk($sformatf("ct_d_gnt%0d", i),  32'(d_gnt),  32'(!exp_if));
      if (i > 0) begin
        chk($sformatf("ct_if_rv%0d", i), 32'(if_rvalid), 32'(prev_if));
        chk($sformatf("ct_d_rv%0d", i),  32'(d_rvalid),  32'(prev_d));
        if (prev_d)  chk($sformatf("ct_d_rd%0d", i),  d_rdata,  32'h3031_3233);
        if (prev_if) chk($sformatf("ct_if_rd%0d", i), if_rdata, 32'h2021_2223);
      end
      prev_if = exp_if; prev_d = !exp_if;
    end
    tick(); if_req = 1'b0; d_req = 1'b0; #2;
    chk("ct_last_if_rv", 32'(if_rvalid), 32'd1);
    chk("ct_last_if_rd", if_rdata,       32'h2021_2223);

    // streaming D
    for (int i = 0; i < 8; i++) begin
      tick(); d_req = 1'b1; d_addr = 32'h40 + 32'(4 * i); #2;
      chk($sformatf("st_gnt%0d", i), 32'(d_gnt), 32'd1);
      if (i > 0) begin
        chk($sformatf("st_rv%0d", i), 32'(d_rvalid), 32'd1);
        chk($sformatf("st_rd%0d", i), d_rdata, word_at(8'(8'h40 + 4 * (i - 1))));
      end
    end
    tick(); d_req = 1'b0; #2;
    chk("st_rv_last", 32'(d_rvalid), 32'd1);
    chk("st_rd_last", d_rdata,       32'h5C5D_5E5F);
    tick(); #2;
    chk("st_rv_drop", 32'(d_rvalid), 32'd0);
    chk("st_rd_hold", d_rdata,       32'h5C5D_5E5F);
    chk("st_rom_hold", rom_addr,     32'h5C);

    // misaligned IF
    tick(); if_req = 1'b1; if_addr = 32'h2; #2;
    chk("mis_gnt", 32'(if_gnt), 32'd1);
`ifdef ROM_ARB_ALIGN_CHK_EN
    chk("mis_rom_addr", rom_addr, 32'h5C);
`else
    chk("mis_rom_addr", rom_addr, 32'h2);
`endif
    tick(); if_req = 1'b0; #2;
    chk("mis_rvalid", 32'(if_rvalid), 32'd1);
`ifdef ROM_ARB_ALIGN_CHK_EN
    chk("mis_err",   32'(if_err), 32'd1);
    chk("mis_rdata", if_rdata,    32'h0);
`else
    chk("mis_err",   32'(if_err), 32'd0);
    chk("mis_rdata", if_rdata,    32'h0203_1300);
`endif
    chk("mis_d_rdata", d_rdata, 32'h5C5D_5E5F);

    // reset mid-access
    tick(); if_req = 1'b1; if_addr = 32'h8; #2;
    tick(); if_req = 1'b0;
    chk("mr_rv_before", 32'(if_rvalid), 32'd1);
    rst_n = 1'b0; #1;
    chk("mr_if_rv",    32'(if_rvalid), 32'd0);
    chk("mr_if_rdata", if_rdata,       32'h0);
    chk("mr_d_rdata",  d_rdata,        32'h0);
    chk("mr_if_err",   32'(if_err),    32'd0);
    tick(); tick(); rst_n = 1'b1;
    tick(); #2;
    chk("mr_post_if_rv", 32'(if_rvalid), 32'd0);
    chk("mr_post_d_rv",  32'(d_rvalid),  32'd0);
    chk("mr_post_rom",   rom_addr,       32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
